// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: fetch state encoding, reset PC, opcodes
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Bits [3:2] give the phase (00 request, 01 wait), bits [1:0] the byte lane
    typedef enum logic [3:0] {
        ST_REQ0  = 4'd0,
        ST_REQ1  = 4'd1,
        ST_REQ2  = 4'd2,
        ST_REQ3  = 4'd3,
        ST_WAIT0 = 4'd4,
        ST_WAIT1 = 4'd5,
        ST_WAIT2 = 4'd6,
        ST_WAIT3 = 4'd7,
        ST_DONE  = 4'd8
    } fetch_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic fetch_state_e req_state(input logic [1:0] k);
        return fetch_state_e'({2'b00, k});
    endfunction

    function automatic fetch_state_e wait_state(input logic [1:0] k);
        return fetch_state_e'({2'b01, k});
    endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage assembling 32-bit words from byte-wide memory
module if_fetch
    import cpu_defs::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_e,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_a,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_din,
    output logic              if_vld,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_is
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [23:0]       buf_q, buf_d;
    logic              if_vld_q, if_vld_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_is_q, if_is_d;

    logic [1:0]        byte_idx;
    logic              in_req, in_wait, in_done;
    logic [ADDR_W-1:0] br_tgt;

    assign byte_idx = state_q[1:0];
    assign in_req   = (state_q[3:2] == 2'b00);
    assign in_wait  = (state_q[3:2] == 2'b01);
    assign in_done  = (state_q == ST_DONE);
    assign br_tgt   = br_addr & ~ADDR_W'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ0;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            if_vld_q <= 1'b0;
            if_pc_q  <= '0;
            if_is_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            if_vld_q <= if_vld_d;
            if_pc_q  <= if_pc_d;
            if_is_q  <= if_is_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (br_e) begin
            state_d = ST_REQ0;
        end else if (in_req) begin
            if (mem_gnt) state_d = wait_state(byte_idx);
        end else if (in_wait) begin
            state_d = (byte_idx == 2'd3) ? ST_DONE : req_state(byte_idx + 2'd1);
        end else if (in_done) begin
            if (!stall) state_d = ST_REQ0;
        end else begin
            state_d = ST_REQ0;
        end
    end

    // A redirect discards any partial word; the byte landing next cycle meets REQ0 and is dropped
    always_comb begin
        pc_d     = pc_q;
        buf_d    = buf_q;
        if_vld_d = if_vld_q;
        if_pc_d  = if_pc_q;
        if_is_d  = if_is_q;
        if (br_e) begin
            pc_d     = br_tgt;
            buf_d    = '0;
            if_vld_d = 1'b0;
            if_is_d  = '0;
        end else if (in_wait) begin
            case (byte_idx)
                2'd0: buf_d[7:0]   = mem_din;
                2'd1: buf_d[15:8]  = mem_din;
                2'd2: buf_d[23:16] = mem_din;
                default: begin
                    if_is_d  = {mem_din, buf_q};
                    if_pc_d  = pc_q + ADDR_W'(4);
                    if_vld_d = 1'b1;
                end
            endcase
        end else if (in_done && !stall) begin
            pc_d     = pc_q + ADDR_W'(4);
            if_vld_d = 1'b0;
            if_is_d  = '0;
        end
    end

    // Request is a pure function of state, gated so nothing goes out during reset
    always_comb begin
        mem_req = 1'b0;
        mem_a   = '0;
        if (!rst && in_req) begin
            mem_req = 1'b1;
            mem_a   = pc_q + ADDR_W'(byte_idx);
        end
    end

    assign if_vld = if_vld_q;
    assign if_pc  = if_pc_q;
    assign if_is  = if_is_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with byte memory model and scoreboard
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] is;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_e = 1'b0;
    logic [31:0] br_addr = '0;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        gnt = 1'b1;
    logic [7:0]  mem_din = 8'hEE;
    logic        if_vld;
    logic [31:0] if_pc;
    logic [31:0] if_is;

    logic        w_rst = 1'b1;
    logic        w_mem_req;
    logic [31:0] w_mem_a;
    logic [7:0]  w_mem_din = 8'hEE;
    logic        w_if_vld;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_is;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .br_e(br_e), .br_addr(br_addr),
        .mem_req(mem_req), .mem_a(mem_a), .mem_gnt(gnt), .mem_din(mem_din),
        .if_vld(if_vld), .if_pc(if_pc), .if_is(if_is)
    );

    if_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(w_rst), .stall(1'b0), .br_e(1'b0), .br_addr(32'h0),
        .mem_req(w_mem_req), .mem_a(w_mem_a), .mem_gnt(1'b1), .mem_din(w_mem_din),
        .if_vld(w_if_vld), .if_pc(w_if_pc), .if_is(w_if_is)
    );

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'hA0;
            32'h3: return 8'h00;
            default: return 8'h5A ^ a[7:0] ^ a[15:8];
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    // Memory answers one cycle after a granted request; junk otherwise so stray captures show up
    always @(posedge clk) begin
        mem_din   <= (mem_req && gnt) ? byte_at(mem_a) : 8'hEE;
        w_mem_din <= w_mem_req ? byte_at(w_mem_a) : 8'hEE;
    end

    task automatic wait_vld(input int max, output int n, output bit ok);
        n = 0;
        while (!if_vld && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = if_vld;
    endtask

    task automatic test_reset;
        rst = 1'b1; gnt = 1'b1; stall = 1'b0; br_e = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if_vld, if_pc, if_is} !== 65'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got vld=%b pc=%h is=%h, expected all 0", if_vld, if_pc, if_is);
        end
        tests_run++;
        if ({mem_req, mem_a} !== 33'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: got req=%b a=%h, expected 0/0", mem_req, mem_a);
        end
    endtask

    task automatic test_first_fetch;
        exp_t e;
        sb.push_back('{pc: 32'h4, is: word_at(32'h0)});
        rst = 1'b0;
        #1;
        for (int n = 0; n <= 9; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 8 && n % 2 == 0) begin
                tests_run++;
                if ({mem_req, mem_a} !== {1'b1, 32'(n / 2)}) begin
                    tests_failed++;
                    $display("FAIL first_req[%0d]: got req=%b a=%h, expected 1/%h", n, mem_req, mem_a, n / 2);
                end
            end else if (n < 8) begin
                tests_run++;
                if ({mem_req, if_vld} !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL first_wait[%0d]: got req=%b vld=%b, expected 0/0", n, mem_req, if_vld);
                end
            end else if (n == 8) begin
                e = sb.pop_front();
                tests_run++;
                if ({if_vld, if_pc, if_is} !== {1'b1, e.pc, e.is}) begin
                    tests_failed++;
                    $display("FAIL first_word: got vld=%b pc=%h is=%h, expected 1/%h/%h", if_vld, if_pc, if_is, e.pc, e.is);
                end
                tests_run++;
                if (if_is !== 32'h00A00513) begin
                    tests_failed++;
                    $display("FAIL first_word_const: got %h, expected 00a00513", if_is);
                end
            end else begin
                tests_run++;
                if ({if_vld, if_is, mem_req, mem_a} !== {1'b0, 32'h0, 1'b1, 32'h4}) begin
                    tests_failed++;
                    $display("FAIL first_after: got vld=%b is=%h req=%b a=%h, expected 0/0/1/4", if_vld, if_is, mem_req, mem_a);
                end
            end
        end
    endtask

    task automatic test_gnt_denied;
        int n, cyc;
        bit ok;
        sb.push_back('{pc: 32'h8, is: word_at(32'h4)});
        repeat (4) @(negedge clk);
        cyc = 4;
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if ({mem_req, mem_a} !== {1'b1, 32'h6}) begin
                tests_failed++;
                $display("FAIL denied_req[%0d]: got req=%b a=%h, expected 1/6", i, mem_req, mem_a);
            end
        end
        gnt = 1'b1;
        wait_vld(20, n, ok);
        cyc += n;
        tests_run++;
        if (!ok || cyc != 11) begin
            tests_failed++;
            $display("FAIL denied_latency: got vld=%b after %0d cycles, expected 1 after 11", ok, cyc);
        end
        last = sb.pop_front();
        tests_run++;
        if ({if_pc, if_is} !== {last.pc, last.is}) begin
            tests_failed++;
            $display("FAIL denied_word: got pc=%h is=%h, expected %h/%h", if_pc, if_is, last.pc, last.is);
        end
    endtask

    task automatic test_stall_done;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({if_vld, if_pc, if_is, mem_req} !== {1'b1, last.pc, last.is, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got vld=%b pc=%h is=%h req=%b, expected 1/%h/%h/0",
                         i, if_vld, if_pc, if_is, mem_req, last.pc, last.is);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({if_vld, mem_req, mem_a} !== {1'b0, 1'b1, 32'h8}) begin
            tests_failed++;
            $display("FAIL stall_release: got vld=%b req=%b a=%h, expected 0/1/8", if_vld, mem_req, mem_a);
        end
    endtask

    task automatic test_redirect_wait;
        int n;
        bit ok;
        exp_t e;
        repeat (3) @(negedge clk);
        br_e = 1'b1;
        br_addr = 32'h0000_0102;
        @(negedge clk);
        br_e = 1'b0;
        tests_run++;
        if ({mem_req, mem_a, if_vld} !== {1'b1, 32'h100, 1'b0}) begin
            tests_failed++;
            $display("FAIL redir_wait_next: got req=%b a=%h vld=%b, expected 1/100/0", mem_req, mem_a, if_vld);
        end
        sb.push_back('{pc: 32'h104, is: word_at(32'h100)});
        wait_vld(20, n, ok);
        tests_run++;
        if (!ok || n != 8) begin
            tests_failed++;
            $display("FAIL redir_wait_latency: got vld=%b after %0d cycles, expected 1 after 8", ok, n);
        end
        e = sb.pop_front();
        tests_run++;
        if ({if_pc, if_is} !== {e.pc, e.is}) begin
            tests_failed++;
            $display("FAIL redir_wait_word: got pc=%h is=%h, expected %h/%h", if_pc, if_is, e.pc, e.is);
        end
    endtask

    task automatic test_redirect_stall;
        int n;
        bit ok;
        exp_t e;
        stall = 1'b1;
        br_e = 1'b1;
        br_addr = 32'h0000_0200;
        @(negedge clk);
        br_e = 1'b0;
        stall = 1'b0;
        tests_run++;
        if ({if_vld, if_is} !== 33'h0) begin
            tests_failed++;
            $display("FAIL redir_stall_drop: got vld=%b is=%h, expected 0/0", if_vld, if_is);
        end
        tests_run++;
        if ({mem_req, mem_a} !== {1'b1, 32'h200}) begin
            tests_failed++;
            $display("FAIL redir_stall_req: got req=%b a=%h, expected 1/200", mem_req, mem_a);
        end
        sb.push_back('{pc: 32'h204, is: word_at(32'h200)});
        wait_vld(20, n, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || {if_pc, if_is} !== {e.pc, e.is}) begin
            tests_failed++;
            $display("FAIL redir_stall_word: got vld=%b pc=%h is=%h, expected 1/%h/%h", ok, if_pc, if_is, e.pc, e.is);
        end
    endtask

    task automatic test_reset_midfetch;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mem_req, mem_a} !== {1'b1, 32'h205}) begin
            tests_failed++;
            $display("FAIL midrst_pre: got req=%b a=%h, expected 1/205", mem_req, mem_a);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_noreq: got req=%b, expected 0", mem_req);
        end
        @(negedge clk);
        tests_run++;
        if ({if_vld, if_pc, if_is, mem_req, mem_a} !== 66'h0) begin
            tests_failed++;
            $display("FAIL midrst_state: got vld=%b pc=%h is=%h req=%b a=%h, expected all 0", if_vld, if_pc, if_is, mem_req, mem_a);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_a} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL midrst_restart: got req=%b a=%h, expected 1/0", mem_req, mem_a);
        end
    endtask

    task automatic test_pc_wrap;
        exp_t e;
        sb.push_back('{pc: 32'h0, is: word_at(32'hFFFF_FFFC)});
        sb.push_back('{pc: 32'h4, is: word_at(32'h0)});
        @(negedge clk);
        w_rst = 1'b0;
        #1;
        for (int n = 0; n <= 17; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 8 || n == 17) begin
                e = sb.pop_front();
                tests_run++;
                if ({w_if_vld, w_if_pc, w_if_is} !== {1'b1, e.pc, e.is}) begin
                    tests_failed++;
                    $display("FAIL wrap_word[%0d]: got vld=%b pc=%h is=%h, expected 1/%h/%h", n, w_if_vld, w_if_pc, w_if_is, e.pc, e.is);
                end
            end else if (n < 8 && n % 2 == 0) begin
                tests_run++;
                if ({w_mem_req, w_mem_a} !== {1'b1, 32'hFFFF_FFFC + 32'(n / 2)}) begin
                    tests_failed++;
                    $display("FAIL wrap_req1[%0d]: got req=%b a=%h, expected 1/%h", n, w_mem_req, w_mem_a, 32'hFFFF_FFFC + 32'(n / 2));
                end
            end else if (n > 8 && n % 2 == 1) begin
                tests_run++;
                if ({w_mem_req, w_mem_a} !== {1'b1, 32'((n - 9) / 2)}) begin
                    tests_failed++;
                    $display("FAIL wrap_req2[%0d]: got req=%b a=%h, expected 1/%h", n, w_mem_req, w_mem_a, (n - 9) / 2);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_gnt_denied();
        test_stall_done();
        test_redirect_wait();
        test_redirect_stall();
        test_reset_midfetch();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
